clk_freq_meter: RTL

- Receive-side checker for divided clocks such as the 1 Hz tick. It samples an asynchronous slow clock `clk_in` in the `clk` domain and measures each period and its high time in `clk` cycles.
- It raises `locked` when the measured period stays within tolerance of the expected value, and flags `timeout` when edges stop arriving.
- It sits beside clock dividers as a self-check and status source for LEDs and debug registers.

---
 rtl/clk_meas_pkg.sv | 9 +
 rtl/sync_edge_det.sv | 25 ++
 rtl/clk_freq_meter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock frequency meter.
package clk_meas_pkg;
    localparam int CNT_W_DEF = 32;

    typedef enum logic {
        ST_WAIT_FIRST = 1'b0,
        ST_MEASURE    = 1'b1
    } state_t;
endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, with a one-cycle rising-edge pulse.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);
    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
            prev     <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
            prev     <= sync_out;
        end
    end

    assign rise = sync_out & ~prev;
endmodule

// File: rtl/clk_freq_meter.sv
// Measures period and high time of an asynchronous slow clock in clk cycles,
// with lock detection against an expected period and a sticky no-edge timeout.
module clk_freq_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int EXPECT_PERIOD = 100000000,
    parameter int TOL           = 1000,
    parameter int LOCK_COUNT    = 2,
    parameter int TIMEOUT       = 200000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);
    localparam int              SW     = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [SW-1:0]   LOCK_L = SW'(LOCK_COUNT);
    localparam logic [CNT_W:0]  EXP_L  = (CNT_W+1)'(EXPECT_PERIOD);
    localparam logic [CNT_W:0]  TOL_L  = (CNT_W+1)'(TOL);
    // 64-bit compare so a TIMEOUT beyond the counter range is simply never reached
    localparam logic [63:0]     TO_L   = 64'(TIMEOUT);

    logic             sync_in, rise;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, hcnt, hcnt_nxt, cnt_inc, hcnt_inc;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic             mv_nxt, locked_nxt, timeout_nxt;
    logic [SW-1:0]    streak, streak_nxt, streak_inc;
    logic [CNT_W:0]   cnt_ext, diff;
    logic             in_tol, at_timeout;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (clk_in),
        .sync_out (sync_in),
        .rise     (rise)
    );

    assign cnt_ext    = {1'b0, cnt};
    assign diff       = (cnt_ext >= EXP_L) ? (cnt_ext - EXP_L) : (EXP_L - cnt_ext);
    assign in_tol     = (diff <= TOL_L);
    assign at_timeout = (64'(cnt) == TO_L);
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign hcnt_inc   = (sync_in && hcnt != '1) ? hcnt + 1'b1 : hcnt;
    assign streak_inc = (streak == LOCK_L) ? streak : streak + 1'b1;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hcnt_nxt    = hcnt;
        period_nxt  = period_out;
        high_nxt    = high_out;
        mv_nxt      = 1'b0;
        locked_nxt  = locked;
        timeout_nxt = timeout;
        streak_nxt  = streak;
        if (!en) begin
            state_nxt  = ST_WAIT_FIRST;
            cnt_nxt    = '0;
            hcnt_nxt   = '0;
            locked_nxt = 1'b0;
            streak_nxt = '0;
        end else begin
            case (state)
                ST_WAIT_FIRST: begin
                    cnt_nxt  = '0;
                    hcnt_nxt = '0;
                    if (rise) begin
                        state_nxt = ST_MEASURE;
                        cnt_nxt   = CNT_W'(1);
                        hcnt_nxt  = CNT_W'(sync_in);
                    end
                end
                ST_MEASURE: begin
                    // A rise in the same cycle as the timeout threshold still counts as a measurement
                    if (rise) begin
                        period_nxt  = cnt;
                        high_nxt    = hcnt;
                        mv_nxt      = 1'b1;
                        timeout_nxt = 1'b0;
                        cnt_nxt     = CNT_W'(1);
                        hcnt_nxt    = CNT_W'(sync_in);
                        if (in_tol) begin
                            streak_nxt = streak_inc;
                            locked_nxt = (streak_inc == LOCK_L);
                        end else begin
                            streak_nxt = '0;
                            locked_nxt = 1'b0;
                        end
                    end else if (at_timeout) begin
                        state_nxt   = ST_WAIT_FIRST;
                        timeout_nxt = 1'b1;
                        locked_nxt  = 1'b0;
                        streak_nxt  = '0;
                        cnt_nxt     = '0;
                        hcnt_nxt    = '0;
                    end else begin
                        cnt_nxt  = cnt_inc;
                        hcnt_nxt = hcnt_inc;
                    end
                end
                default: state_nxt = ST_WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_WAIT_FIRST;
            cnt        <= '0;
            hcnt       <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            streak     <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hcnt       <= hcnt_nxt;
            period_out <= period_nxt;
            high_out   <= high_nxt;
            meas_valid <= mv_nxt;
            locked     <= locked_nxt;
            timeout    <= timeout_nxt;
            streak     <= streak_nxt;
        end
    end
endmodule
